// File: rtl/nibble_alu_seq.sv
// Multi-cycle ALU that walks a 4-bit carry-lookahead slice across WIDTH bits, one nibble per clock.
// Optional macro NIBBLE_ALU_FLUSH_EN adds a flush input that abandons the current operation.
module nibble_alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef NIBBLE_ALU_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             op_err
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned SW  = CW + 2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, SLTFIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             carry, carry_nxt;
  logic [WIDTH-1:0] a_r, a_nxt, b_r, b_nxt;
  logic [2:0]       op_r, op_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             zero_nxt, cout_nxt, ovf_nxt, err_nxt;
  logic             in_ready_nxt, out_valid_nxt;
  logic             flush_req;

`ifdef NIBBLE_ALU_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Slice inputs and carry-lookahead network for the current nibble
  logic [SW-1:0] sh;
  logic          op_sub, op_arith, op_legal, less;
  logic [3:0]    an, bn, g, p, sum, slice;
  logic          c1, c2, c3, c4;

  always_comb begin
    sh       = {cnt, 2'b00};
    op_sub   = (op_r == OP_SUB) || (op_r == OP_SLT);
    op_arith = op_sub || (op_r == OP_ADD);
    op_legal = op_arith || (op_r == OP_AND) || (op_r == OP_OR);
    an  = 4'(a_r >> sh);
    bn  = 4'(b_r >> sh) ^ {4{op_sub}};
    g   = an & bn;
    p   = an ^ bn;
    c1  = g[0] | (p[0] & carry);
    c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
        | (p[3] & p[2] & p[1] & p[0] & carry);
    sum = p ^ {c3, c2, c1, carry};
    unique case (op_r)
      OP_AND:                 slice = g;
      OP_OR:                  slice = an | bn;
      OP_ADD, OP_SUB, OP_SLT: slice = sum;
      default:                slice = 4'h0;
    endcase
    less = result[WIDTH-1] ^ overflow;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    carry_nxt  = carry;
    a_nxt      = a_r;
    b_nxt      = b_r;
    op_nxt     = op_r;
    result_nxt = result;
    zero_nxt   = zero;
    cout_nxt   = carry_out;
    ovf_nxt    = overflow;
    err_nxt    = op_err;

    unique case (state)
      IDLE: begin
        if (!flush_req && in_valid) begin
          a_nxt     = a;
          b_nxt     = b;
          op_nxt    = alu_op;
          carry_nxt = (alu_op == OP_SUB) || (alu_op == OP_SLT);
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush_req) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          result_nxt = (result & ~(WIDTH'(4'hf) << sh)) | (WIDTH'(slice) << sh);
          carry_nxt  = c4;
          if (cnt == CW'(NIB - 1)) begin
            cout_nxt  = op_arith & c4;
            ovf_nxt   = op_arith & (c3 ^ c4);
            err_nxt   = !op_legal;
            zero_nxt  = (result_nxt == '0);
            state_nxt = (op_r == OP_SLT) ? SLTFIX : DONE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      SLTFIX: begin
        if (flush_req) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else begin
          result_nxt = WIDTH'(less);
          zero_nxt   = !less;
          cout_nxt   = 1'b0;
          ovf_nxt    = 1'b0;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (flush_req) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= OP_AND;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      op_err    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      carry     <= carry_nxt;
      a_r       <= a_nxt;
      b_r       <= b_nxt;
      op_r      <= op_nxt;
      result    <= result_nxt;
      zero      <= zero_nxt;
      carry_out <= cout_nxt;
      overflow  <= ovf_nxt;
      op_err    <= err_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_nibble_alu_seq.sv
// Randomised self-checking bench for nibble_alu_seq against an arithmetic reference model.
module tb_nibble_alu_seq;

  localparam int unsigned W   = 32;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   alu_op = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry_out, overflow, op_err;
`ifdef NIBBLE_ALU_FLUSH_EN
  logic         flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
`ifdef NIBBLE_ALU_FLUSH_EN
    .flush(flush),
`endif
    .result(result), .zero(zero), .carry_out(carry_out), .overflow(overflow), .op_err(op_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no nibbles
  function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic co, output logic ov,
                                output logic er);
    logic [W:0] full;
    r = '0; co = 1'b0; ov = 1'b0; er = 1'b0;
    case (op)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin
        full = {1'b0, x} + {1'b0, y};
        r  = full[W-1:0];
        co = full[W];
        ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'b110: begin
        r  = x - y;
        co = (x >= y);
        ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'b111: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: er = 1'b1;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int hold, input bit keep_valid);
    logic [W-1:0] er_res;
    logic         e_co, e_ov, e_err;
    int           n, exp_lat;
    model(op, x, y, er_res, e_co, e_ov, e_err);
    exp_lat = (op == 3'b111) ? NIB + 2 : NIB + 1;
    @(negedge clk);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    alu_op    = op;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    else begin
      a = ~x;
      b = ~y;
    end
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ":latency"}, 64'(n), 64'(exp_lat));
    check({tag, ":result"}, 64'(result), 64'(er_res));
    check({tag, ":zero"}, 64'(zero), 64'(er_res == '0));
    check({tag, ":carry_out"}, 64'(carry_out), 64'(e_co));
    check({tag, ":overflow"}, 64'(overflow), 64'(e_ov));
    check({tag, ":op_err"}, 64'(op_err), 64'(e_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, ":hold_result"}, 64'(result), 64'(er_res));
      check({tag, ":hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    if (hold > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, ":valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, ":ready_back"}, 64'(in_ready), 64'(1));
  endtask

  task automatic start_only(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    alu_op    = op;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check({tag, ":no_out_valid"}, 64'(saw), 64'(0));
  endtask

  initial begin
    logic [2:0]   ops [6];
    logic [W-1:0] x, y;
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011};

    #12;
    check("rst:in_ready", 64'(in_ready), 64'(1));
    check("rst:out_valid", 64'(out_valid), 64'(0));
    check("rst:result", 64'(result), 64'(0));
    check("rst:flags", 64'({zero, carry_out, overflow, op_err}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
    run_op("sub_ovf", 3'b110, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
    run_op("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
    run_op("slt_ovf", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);
    run_op("and_bp", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 1'b1);
    run_op("illegal", 3'b011, 32'h1234_5678, 32'h0000_0001, 0, 1'b0);
    run_op("after_illegal", 3'b001, 32'h1234_5678, 32'h0000_0001, 0, 1'b0);
    run_op("sub_eq", 3'b110, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1'b0);

    // Asynchronous reset while nibble 4 of an ADD is in flight
    start_only(3'b010, 32'h1357_9BDF, 32'h2468_ACE0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid:in_ready", 64'(in_ready), 64'(1));
    check("rst_mid:out_valid", 64'(out_valid), 64'(0));
    check("rst_mid:result", 64'(result), 64'(0));
    check("rst_mid:flags", 64'({zero, carry_out, overflow, op_err}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("rst_mid", 15);

`ifdef NIBBLE_ALU_FLUSH_EN
    start_only(3'b110, 32'h0000_0005, 32'h0000_0009);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_run:in_ready", 64'(in_ready), 64'(1));
    check("flush_run:op_err", 64'(op_err), 64'(0));
    expect_quiet("flush_run", 15);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_idle:in_ready", 64'(in_ready), 64'(1));
    expect_quiet("flush_idle", 12);
`endif

    for (int t = 0; t < 40; t++) begin
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 4))
        0: y = x;
        1: x = {1'b1, 31'($urandom())};
        2: y = '0;
        default: ;
      endcase
      run_op($sformatf("rand%0d", t), ops[$urandom_range(0, 5)], x, y,
             int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_alu_seq.md
Name: nibble_alu_seq

Overview:
- Multi-cycle sequencer that feeds and consumes the 4-bit carry-lookahead ALU slice, one nibble per clock.
- Bits processed LSB-first; carry held in a register between nibbles; zero and SLT `less` resolved at the end.
- Used as an area-reduced EX-stage ALU for a WIDTH-bit MIPS datapath.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4.
- NIB, WIDTH/4, number of nibble cycles (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  block can accept; high only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all other codes illegal
- out_valid  output  1  result fields are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  ALU result
- zero  output  1  1 when result == 0 (true-high)
- carry_out  output  1  final carry out of the top nibble (ADD/SUB only; 0 otherwise)
- overflow  output  1  signed overflow (ADD/SUB only; 0 otherwise)
- op_err  output  1  an illegal alu_op was accepted

Behaviour:
- Reset: clk and rst_n are the clock and reset. Reset is asynchronous and active-low. While rst_n = 0:
  - state = IDLE; in_ready = 1.
  - out_valid, result, zero, carry_out, overflow, op_err = 0.
  - Nibble counter and carry register = 0.
  - Reset mid-operation abandons the operation; no out_valid is produced for it.
- States: IDLE, RUN, SLTFIX, DONE.
- IDLE:
  - in_valid & in_ready: latch a, b, alu_op.
  - Carry register <= 1 for SUB/SLT, else 0.
  - Counter <= 0; go to RUN.
- RUN, per cycle, for nibble k = counter:
  - Compute the 4-bit slice of a[4k+3:4k] and b'[4k+3:4k], where b' = ~b for SUB/SLT.
  - Write result bits 4k+3:4k; update the carry register with the slice carry out.
  - At k = NIB-1:
    - Capture carry_out.
    - overflow = carry into MSB XOR carry out of MSB.
    - Go to SLTFIX if SLT, else DONE.
- SLTFIX:
  - less = sum[WIDTH-1] XOR overflow (overflow-corrected).
  - result <= {WIDTH-1 zeros, less}.
  - carry_out and overflow forced to 0; go to DONE.
- DONE:
  - out_valid = 1; zero computed from the final result.
  - All outputs held stable until out_ready = 1, then go to IDLE next edge.
  - in_ready = 0 throughout; in_valid is ignored while not IDLE.
- Latency (accept edge to out_valid high):
  - NIB+1 cycles for AND/OR/ADD/SUB (9 at WIDTH = 32).
  - NIB+2 cycles for SLT (10).
  - Throughput is one operation per latency+1 cycles when out_ready is held high.
- Illegal alu_op:
  - Runs the full NIB cycles with result forced to 0; enters DONE with zero = 1, op_err = 1.
  - op_err clears on the next accept.
- out_valid deasserts the cycle after out_ready is sampled high in DONE.
- Result-register bits are not all cleared on accept; out_valid alone qualifies them.
- AND/OR: carry register unused; carry_out and overflow = 0.

Optional Feature:
- Macro: NIBBLE_ALU_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit). flush = 1 at a clock edge in RUN, SLTFIX or DONE returns the block to IDLE.
  - out_valid = 0 the next cycle; the result is discarded and op_err cleared.
  - flush has priority over out_ready.
  - flush in IDLE takes priority over an in_valid accept in the same cycle (operation not accepted).
- Not defined:
  - No flush port.
  - Once accepted, an operation can only be terminated by rst_n.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001, out_ready=1 → out_valid 9 cycles after accept; result=0x00000000, zero=1, carry_out=1, overflow=0.
- SUB a=0x80000000, b=0x00000001 → result=0x7FFFFFFF, overflow=1, carry_out=1, zero=0.
- SLT a=0xFFFFFFFF, b=0x00000001 → result=0x00000001, latency 10. SLT a=0x7FFFFFFF, b=0x80000000 → result=0x00000000, zero=1 (overflow-corrected).
- Back-pressure: AND a=0xF0F0F0F0, b=0xFF00FF00, out_ready=0 for 5 cycles after out_valid, in_valid=1 throughout:
  - result=0xF000F000 held stable; in_ready=0; second operand set not accepted.
  - After out_ready=1: out_valid drops, in_ready=1.
- Reset mid-RUN: assert rst_n=0 asynchronously at nibble 4 of an ADD → all outputs 0 immediately, in_ready=1; after release, no out_valid until a new accept.
- Illegal op 011 with a=0x12345678, b=1 → result=0, zero=1, op_err=1 after 9 cycles. With NIBBLE_ALU_FLUSH_EN, flush=1 at nibble 3 of any op → IDLE next cycle, out_valid never asserts.
